// File: rtl/relu_stream_arbiter.sv
// Frame-locked two-requester round-robin arbiter feeding one shared ReLU stage.
// A grant covers a whole frame; the ReLU result sits in a single output register.
module relu_stream_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_ELEMENTS = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req0_valid,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] req0_data,
  input  logic                               req0_last,
  output logic                               req0_ready,
  input  logic                               req1_valid,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] req1_data,
  input  logic                               req1_last,
  output logic                               req1_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] out_data,
  output logic                               out_src,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int W = DATA_WIDTH * NUM_ELEMENTS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Negative elements (sign bit set) clamp to zero; others pass unchanged.
  function automatic logic [W-1:0] relu_beat(input logic [W-1:0] beat);
    logic [W-1:0] res;
    res = {W{1'b0}};
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (beat[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
        res[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end else begin
        res[i*DATA_WIDTH +: DATA_WIDTH] = beat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return res;
  endfunction

  state_t         state_r;
  logic           prio_r;
  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic           out_src_r;
  logic           out_last_r;

  logic           can_load_s;
  logic           accept0_s;
  logic           accept1_s;
  logic           accept_s;
  logic [W-1:0]   beat_data_s;
  logic           beat_last_s;
  logic           beat_src_s;

  // Handshake decode: ready depends only on state and the output register, never on valid.
  always_comb begin
    can_load_s  = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    can_load_s  = !out_valid_r || out_ready;
    req0_ready  = (state_r == GRANT0) && can_load_s;
    req1_ready  = (state_r == GRANT1) && can_load_s;
  end

  // Beat selection for the granted requester.
  always_comb begin
    accept0_s   = req0_valid && req0_ready;
    accept1_s   = req1_valid && req1_ready;
    accept_s    = accept0_s || accept1_s;
    beat_data_s = {W{1'b0}};
    beat_last_s = 1'b0;
    beat_src_s  = 1'b0;
    if (state_r == GRANT1) begin
      beat_data_s = req1_data;
      beat_last_s = req1_last;
      beat_src_s  = 1'b1;
    end else begin
      beat_data_s = req0_data;
      beat_last_s = req0_last;
      beat_src_s  = 1'b0;
    end
  end

  // Arbitration FSM: one IDLE cycle decides, grant is released only on an accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      prio_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            state_r <= prio_r ? GRANT1 : GRANT0;
          end else if (req0_valid) begin
            state_r <= GRANT0;
          end else if (req1_valid) begin
            state_r <= GRANT1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT0: begin
          if (accept0_s && req0_last) begin
            state_r <= IDLE;
            prio_r  <= 1'b1;
          end else begin
            state_r <= GRANT0;
          end
        end
        GRANT1: begin
          if (accept1_s && req1_last) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
          end else begin
            state_r <= GRANT1;
          end
        end
        default: begin
          state_r <= IDLE;
          prio_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on accept (also when popping), clear valid on a pop with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= relu_beat(beat_data_s);
        out_src_r   <= beat_src_s;
        out_last_r  <= beat_last_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Bench for relu_stream_arbiter: ReLU vector table, directed frame sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_relu_stream_arbiter;

  localparam int DW = 8;
  localparam int NE = 16;
  localparam int W  = DW * NE;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_last, req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] req1_data;
  logic         out_valid, out_src, out_last, out_ready, busy;
  logic [W-1:0] out_data;

  relu_stream_arbiter #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic l; } beat_t;
  typedef struct { logic [W-1:0] din; logic [W-1:0] exp; } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  int    order[$];
  int    total = 0;
  int    bad = 0;
  logic  pend0, pend1, sof;
  int    acc_cnt;

  // reference model state
  int           m_owner;
  int           m_prio;
  logic         m_ov, m_src, m_last;
  logic [W-1:0] m_od;

  function automatic logic [W-1:0] ref_relu(input logic [W-1:0] x);
    logic [W-1:0] r;
    int e;
    r = {W{1'b0}};
    for (int i = 0; i < NE; i++) begin
      e = $signed(x[i*DW +: DW]);
      if (e > 0) r[i*DW +: DW] = e[DW-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int who, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.l = (k == len - 1);
      if (who == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input int vp0, input int vp1, input int rp);
    logic r0, r1, a0, a1;
    if (!pend0) begin
      if (q0.size() > 0 && $urandom_range(99) < vp0) begin
        req0_valid = 1'b1; req0_data = q0[0].d; req0_last = q0[0].l;
      end else req0_valid = 1'b0;
    end
    if (!pend1) begin
      if (q1.size() > 0 && $urandom_range(99) < vp1) begin
        req1_valid = 1'b1; req1_data = q1[0].d; req1_last = q1[0].l;
      end else req1_valid = 1'b0;
    end
    out_ready = ($urandom_range(99) < rp);
    #1;
    r0 = (m_owner == 0) && (!m_ov || out_ready);
    r1 = (m_owner == 1) && (!m_ov || out_ready);
    chk("ctl{valid,src,last,busy,rdy0,rdy1}",
        {out_valid, out_src, out_last, busy, req0_ready, req1_ready},
        {m_ov, m_src, m_last, (m_owner >= 0), r0, r1});
    chk("out_data", out_data, m_od);
    if (out_valid && out_ready) begin
      if (sof) order.push_back(int'(out_src));
      sof = out_last;
    end
    a0 = r0 && req0_valid;
    a1 = r1 && req1_valid;
    if (m_owner < 0) begin
      if (req0_valid && req1_valid) m_owner = m_prio;
      else if (req0_valid) m_owner = 0;
      else if (req1_valid) m_owner = 1;
    end else if ((a0 && req0_last) || (a1 && req1_last)) begin
      m_prio  = 1 - m_owner;
      m_owner = -1;
    end
    if (a0 || a1) begin
      m_ov   = 1'b1;
      m_od   = ref_relu(a1 ? req1_data : req0_data);
      m_src  = a1;
      m_last = a1 ? req1_last : req0_last;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (a0) begin void'(q0.pop_front()); acc_cnt++; end
    if (a1) begin void'(q1.pop_front()); acc_cnt++; end
    pend0 = req0_valid && !a0;
    pend1 = req1_valid && !a1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    q0.delete(); q1.delete(); order.delete();
    pend0 = 1'b0; pend1 = 1'b0; sof = 1'b1;
    m_owner = -1; m_prio = 0; m_ov = 1'b0; m_src = 1'b0; m_last = 1'b0; m_od = {W{1'b0}};
    #1;
    chk("rst{valid,src,last,busy}", {out_valid, out_src, out_last, busy}, {W{1'b0}});
    chk("rst_data", out_data, {W{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int vp0, input int vp1, input int rp, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0 || m_ov) && n < budget) begin
      cycle(vp0, vp1, rp);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic chk_order(input string name, input int exp[$]);
    chk({name, "_len"}, order.size(), exp.size());
    for (int j = 0; j < exp.size() && j < order.size(); j++) chk(name, order[j], exp[j]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[6];
    int   n;
    tv[0] = '{128'h40404040_40404040_4040407f_0100ff80, 128'h40404040_40404040_4040407f_01000000};
    tv[1] = '{128'h80808080_80808080_80808080_80808080, 128'h00000000_00000000_00000000_00000000};
    tv[2] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h00000000_00000000_00000000_00000000};
    tv[3] = '{128'h7f7f7f7f_7f7f7f7f_7f7f7f7f_7f7f7f7f, 128'h7f7f7f7f_7f7f7f7f_7f7f7f7f_7f7f7f7f};
    tv[4] = '{128'h01234567_89abcdef_fedcba98_76543210, 128'h01234567_00000000_00000000_76543210};
    tv[5] = '{128'h807f807f_807f807f_807f807f_807f807f, 128'h007f007f_007f007f_007f007f_007f007f};

    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = {W{1'b0}}; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = {W{1'b0}}; req1_last = 1'b0;
    do_reset();

    // single-beat req0 frames: 1-cycle arbitration bubble then element-wise ReLU
    foreach (tv[i]) begin
      q0.push_back('{tv[i].din, 1'b1});
      n = 0;
      while (q0.size() > 0 && n < 8) begin cycle(100, 0, 100); n++; end
      chk("bubble_cycles", n, 2);
      chk("relu_table", out_data, tv[i].exp);
      cycle(0, 0, 100);
    end

    // simultaneous 3-beat frames, with a 4-cycle output stall mid-frame
    do_reset();
    push_frame(0, 3); push_frame(1, 3); push_frame(0, 3); push_frame(1, 3);
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0 || m_ov) && n < 80) begin
      cycle(100, 100, (n >= 4 && n < 8) ? 0 : 100);
      n++;
    end
    chk("seqA_done", n < 80, 1'b1);
    chk_order("seqA_order", '{0, 1, 0, 1});

    // granted requester drops valid mid-frame while the other waits
    do_reset();
    push_frame(0, 4); push_frame(1, 2);
    for (int c = 0; c < 4; c++) cycle(100, 100, 100);
    for (int c = 0; c < 3; c++) cycle(0, 100, 100);
    drain(100, 100, 100, 60);
    chk_order("drop_order", '{0, 1});

    // reset during beat 2 of a 4-beat req0 frame, then a req1 frame
    do_reset();
    push_frame(0, 4);
    acc_cnt = 0; n = 0;
    while (acc_cnt < 2 && n < 20) begin cycle(100, 0, 100); n++; end
    chk("midframe_beats", acc_cnt, 2);
    do_reset();
    push_frame(1, 2);
    drain(0, 100, 100, 40);
    chk_order("post_reset_order", '{1});

    // only req1 from reset, then a tie goes back to req0
    do_reset();
    push_frame(1, 2);
    drain(0, 100, 100, 40);
    push_frame(0, 1); push_frame(1, 1);
    drain(100, 100, 100, 40);
    chk_order("prio_order", '{1, 0, 1});

    // randomized traffic with backpressure and valid gaps
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (q0.size() < 3) push_frame(0, $urandom_range(4, 1));
      if (q1.size() < 3) push_frame(1, $urandom_range(4, 1));
      cycle(70, 70, 70);
    end
    drain(70, 70, 70, 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
